// File: rtl/div_seq.sv
// div_seq: sequential 8-bit by 4-bit unsigned restoring divider.
//
// A 9-bit accumulator holds the partial remainder in acc[8:4] and the dividend
// bits in acc[3:0]; each quotient bit takes one SHIFT cycle and one conditional
// SUB cycle. Four iterations produce a 4-bit quotient and a 4-bit remainder.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides every other input
//   start      division request, only sampled while idle
//   dividendo  8-bit dividend, captured on the accepting edge
//   divisor    4-bit divisor, captured on the accepting edge
//   quociente  registered quotient, held until the next completed operation
//   resto      registered remainder, held until the next completed operation
//   done       one-cycle pulse; quociente/resto/ovf are valid in this cycle
//   ocupado    high in every state except idle
//   ovf        registered overflow flag
//
// Optional feature: define DIV_OVERFLOW_EN to detect divisor == 0 or a quotient
// that would not fit in 4 bits on the accepting edge; the block then skips the
// iterations, reports ovf=1, quociente=4'hF, resto=0 and goes straight to DONE.
// Without the macro ovf is always 0 and every request runs the full sequence.

module div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividendo,
  input  logic [3:0] divisor,
  output logic [3:0] quociente,
  output logic [3:0] resto,
  output logic       done,
  output logic       ocupado,
  output logic       ovf
);

  typedef enum logic [1:0] {StIdle, StShift, StSub, StDone} state_e;

  state_e      state_q, state_d;
  logic [8:0]  acc_q, acc_d;
  logic [3:0]  dvs_q, dvs_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  quo_q, quo_d;
  logic [3:0]  rem_q, rem_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  logic        take;
  logic [4:0]  diff;
  logic        ovf_hit;

  always_comb begin
    // Partial remainder compared against the zero-extended divisor.
    take = acc_q[8:4] >= {1'b0, dvs_q};
    diff = acc_q[8:4] - {1'b0, dvs_q};

`ifdef DIV_OVERFLOW_EN
    // Quotient fits in 4 bits only if the dividend's upper nibble is below the divisor.
    ovf_hit = (divisor == 4'd0) || (dividendo[7:4] >= divisor);
`else
    ovf_hit = 1'b0;
`endif

    state_d = state_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = {1'b0, dividendo};
          dvs_d   = divisor;
          cnt_d   = 2'd0;
          ovf_d   = 1'b0;
          state_d = StShift;
          if (ovf_hit) begin
            ovf_d   = 1'b1;
            quo_d   = 4'hF;
            rem_d   = 4'h0;
            state_d = StDone;
          end
        end
      end
      StShift: begin
        acc_d   = {acc_q[7:0], 1'b0};
        state_d = StSub;
      end
      StSub: begin
        if (take) begin
          acc_d = {diff, acc_q[3:1], 1'b1};
        end
        if (cnt_q == 2'd3) begin
          // Results are taken from the post-subtract accumulator.
          quo_d   = acc_d[3:0];
          rem_d   = acc_d[7:4];
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          state_d = StShift;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered off the next state so they line up with it.
    done_d = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= 9'd0;
      dvs_q   <= 4'd0;
      cnt_q   <= 2'd0;
      quo_q   <= 4'd0;
      rem_q   <= 4'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign quociente = quo_q;
  assign resto     = rem_q;
  assign done      = done_q;
  assign ocupado   = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: operations with hand-computed quotient, remainder,
// overflow flag, done timing and busy duration, plus ignored-start and reset-abort cases.

module tb_div_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividendo;
  logic [3:0] divisor;
  logic [3:0] quociente;
  logic [3:0] resto;
  logic       done;
  logic       ocupado;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .quociente (quociente),
    .resto     (resto),
    .done      (done),
    .ocupado   (ocupado),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Accepts one request, then samples #1 after every edge until done (bounded).
  // done_edge is the edge index (accepting edge = 0) after which done is seen.
  // With inject set, a second start with other operands is pulsed while busy.
  task automatic run_op(input string tag, input logic [7:0] dd, input logic [3:0] dv,
                        input int exp_q, input int exp_r, input int exp_ovf,
                        input int exp_edge, input bit inject);
    int  done_edge;
    int  busy;
    bit  seen;
    done_edge = -1;
    busy      = 0;
    seen      = 1'b0;
    @(negedge clk);
    dividendo = dd;
    divisor   = dv;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    // Operand changes after acceptance must have no effect.
    dividendo = 8'hFF;
    divisor   = 4'h1;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (inject && k == 2) begin
        start     = 1'b1;
        dividendo = 8'd50;
        divisor   = 4'd3;
      end
      if (inject && k == 3) start = 1'b0;
      if (ocupado) busy++;
      if (done) begin
        seen      = 1'b1;
        done_edge = k;
      end
    end
    check({tag, "_done_edge"}, done_edge, exp_edge);
    check({tag, "_busy_cycles"}, busy, exp_edge + 1);
    check({tag, "_q"}, int'(quociente), exp_q);
    check({tag, "_r"}, int'(resto), exp_r);
    check({tag, "_ovf"}, int'(ovf), exp_ovf);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse_end"}, int'(done), 0);
    check({tag, "_idle_after"}, int'(ocupado), 0);
    check({tag, "_q_hold"}, int'(quociente), exp_q);
  endtask

  initial begin
    int done_seen;
    rst       = 1'b1;
    start     = 1'b0;
    dividendo = 8'd0;
    divisor   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", int'(quociente), 0);
    check("rst_r", int'(resto), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(ocupado), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    run_op("d100_7", 8'd100, 4'd7, 14, 2, 0, 8, 1'b0);
    run_op("d77_5", 8'd77, 4'd5, 15, 2, 0, 8, 1'b0);
    run_op("d0_3", 8'd0, 4'd3, 0, 0, 0, 8, 1'b0);
`ifdef DIV_OVERFLOW_EN
    run_op("d128_3", 8'h80, 4'd3, 15, 0, 1, 0, 1'b0);
    run_op("d37_0", 8'h25, 4'd0, 15, 0, 1, 0, 1'b0);
`else
    // Truncated algorithmic results of overflowing divisions.
    run_op("d128_3", 8'h80, 4'd3, 15, 3, 0, 8, 1'b0);
    run_op("d37_0", 8'h25, 4'd0, 15, 5, 0, 8, 1'b0);
`endif
    run_op("ign_start", 8'd100, 4'd7, 14, 2, 0, 8, 1'b1);
    run_op("d40_3", 8'd40, 4'd3, 13, 1, 0, 8, 1'b0);

    // Reset mid-operation: accept 100/7, raise rst after edge 3, abort on edge 4.
    @(negedge clk);
    dividendo = 8'd100;
    divisor   = 4'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", int'(ocupado), 0);
    check("abort_q", int'(quociente), 0);
    check("abort_r", int'(resto), 0);
    check("abort_done", int'(done), 0);
    done_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_op("after_abort", 8'd100, 4'd7, 14, 2, 0, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
